// File: rtl/hpi_bus_sequencer.sv
// Turns PIO-level HPI requests from software into one timed CY7C67200 bus cycle
// (setup, strobe, hold) and returns captured read data to the PIO.
module hpi_bus_sequencer #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [1:0]  sw_address_i,
  input  logic        sw_cs_n_i,
  input  logic        sw_r_n_i,
  input  logic        sw_w_n_i,
  input  logic [15:0] sw_data_out_i,
  output logic [15:0] sw_data_in_o,
  output logic        busy_o,
  output logic        proto_err_o,
  output logic [1:0]  otg_addr_o,
  output logic        otg_cs_n_o,
  output logic        otg_rd_n_o,
  output logic        otg_wr_n_o,
  inout  wire  [15:0] otg_data_io
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    WAIT_REL
  } state_e;

  localparam logic [3:0] SetupLast  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] StrobeLast = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HoldLast   = 4'(HOLD_CYC - 1);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [1:0]  addr_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;
  logic        is_read_q;
  logic        oe_q;
  logic        cs_n_q;
  logic        rd_n_q;
  logic        wr_n_q;
  logic        busy_q;
  logic        proto_err_q;

  logic req_read;
  logic req_write;
  logic req_illegal;
  logic pio_released;

  assign req_read     = !sw_cs_n_i && !sw_r_n_i &&  sw_w_n_i;
  assign req_write    = !sw_cs_n_i &&  sw_r_n_i && !sw_w_n_i;
  assign req_illegal  = !sw_cs_n_i && !sw_r_n_i && !sw_w_n_i;
  assign pio_released =  sw_cs_n_i &&  sw_r_n_i &&  sw_w_n_i;

  // Each phase loads (length - 1) on entry and hands over when the counter hits zero.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= 2'd0;
      wdata_q     <= 16'h0000;
      rdata_q     <= 16'h0000;
      is_read_q   <= 1'b0;
      oe_q        <= 1'b0;
      cs_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_illegal) begin
            proto_err_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= WAIT_REL;
          end else if (req_read || req_write) begin
            addr_q    <= sw_address_i;
            wdata_q   <= sw_data_out_i;
            is_read_q <= req_read;
            oe_q      <= req_write;
            cs_n_q    <= 1'b0;
            busy_q    <= 1'b1;
            cnt_q     <= SetupLast;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_q == 4'd0) begin
            rd_n_q  <= !is_read_q;
            wr_n_q  <= is_read_q;
            cnt_q   <= StrobeLast;
            state_q <= STROBE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        STROBE: begin
          // Read data is taken on the same edge that releases RD_N.
          if (cnt_q == 4'd0) begin
            rd_n_q <= 1'b1;
            wr_n_q <= 1'b1;
            if (is_read_q) begin
              rdata_q <= otg_data_io;
            end
            cnt_q   <= HoldLast;
            state_q <= HOLD;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        HOLD: begin
          if (cnt_q == 4'd0) begin
            cs_n_q  <= 1'b1;
            oe_q    <= 1'b0;
            state_q <= WAIT_REL;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        WAIT_REL: begin
          if (pio_released) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign otg_data_io  = oe_q ? wdata_q : 16'hzzzz;
  assign otg_addr_o   = addr_q;
  assign otg_cs_n_o   = cs_n_q;
  assign otg_rd_n_o   = rd_n_q;
  assign otg_wr_n_o   = wr_n_q;
  assign busy_o       = busy_q;
  assign proto_err_o  = proto_err_q;
  assign sw_data_in_o = rdata_q;

endmodule
